// File: rtl/bcd_pkg.sv
// Shared types, constants and helpers for the BCD down counter.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_ZERO = 4'd0;
    localparam bcd_digit_t BCD_NINE = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        DONE
    } bcd_dn_state_t;

    // Any nibble above nine is forced to nine so the count never holds an illegal code.
    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
        return (d > BCD_NINE) ? BCD_NINE : d;
    endfunction

endpackage

// File: rtl/bcd_down_counter_digit.sv
// One BCD digit of the down counter: loads a preset or decrements with wrap 0 -> 9.
module bcd_digit_down
    import bcd_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  bcd_digit_t load_digit,
    input  logic       dec_en,
    output bcd_digit_t digit,
    output logic       is_zero
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            digit <= BCD_ZERO;
        end else if (load) begin
            digit <= bcd_clamp(load_digit);
        end else if (dec_en) begin
            digit <= (digit == BCD_ZERO) ? BCD_NINE : digit - 4'd1;
        end
    end

    assign is_zero = (digit == BCD_ZERO);

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD countdown counter with load/run/pause/done sequencing.
// Optional feature: define BCD_DOWN_AUTORELOAD_EN to reload from a shadow preset at terminal count.
module bcd_down_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  tick,
    output logic [4*DIGITS-1:0]   count,
    output logic                  busy,
    output logic                  done
);

    localparam logic [4*DIGITS-1:0] COUNT_ONE = 1;

    bcd_dn_state_t         state;
    bcd_dn_state_t         next_state;
    logic [DIGITS-1:0]     dec_en;
    logic [DIGITS-1:0]     is_zero;
    logic [4*DIGITS-1:0]   clamped;
    logic [4*DIGITS-1:0]   shadow_value;
    logic [4*DIGITS-1:0]   digit_src;
    logic                  digit_load;
    logic                  do_dec;
    logic                  do_reload;
    logic                  done_next;
    logic                  reload_ok;
    logic                  count_is_zero;
    logic                  count_is_one;

    assign count_is_zero = &is_zero;
    assign count_is_one  = (count == COUNT_ONE);

`ifdef BCD_DOWN_AUTORELOAD_EN
    logic [4*DIGITS-1:0] shadow;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shadow <= '0;
        end else if (load) begin
            shadow <= clamped;
        end
    end

    assign shadow_value = shadow;
    assign reload_ok    = (shadow != '0);
`else
    assign shadow_value = '0;
    assign reload_ok    = 1'b0;
`endif

    assign digit_load = load | do_reload;
    assign digit_src  = load ? clamped : shadow_value;

    // Borrow chain: a digit only steps when every digit below it is already zero.
    assign dec_en[0] = do_dec;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        if (g > 0) begin : g_borrow
            assign dec_en[g] = dec_en[g-1] & is_zero[g-1];
        end

        assign clamped[4*g +: 4] = bcd_clamp(load_value[4*g +: 4]);

        bcd_digit_down u_digit (
            .clock      (clock),
            .reset      (reset),
            .load       (digit_load),
            .load_digit (digit_src[4*g +: 4]),
            .dec_en     (dec_en[g]),
            .digit      (count[4*g +: 4]),
            .is_zero    (is_zero[g])
        );
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state == RUN) || (next_state == PAUSED);
            done  <= done_next;
        end
    end

    // Load overrides everything; pause beats start, which beats tick.
    always_comb begin
        next_state = state;
        do_dec     = 1'b0;
        do_reload  = 1'b0;
        done_next  = 1'b0;
        if (load) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !count_is_zero) begin
                        next_state = RUN;
                    end
                end
                RUN: begin
                    if (pause) begin
                        next_state = PAUSED;
                    end else if (tick && count_is_one) begin
                        if (reload_ok) begin
                            do_reload = 1'b1;
                            done_next = 1'b1;
                        end else begin
                            do_dec     = 1'b1;
                            next_state = DONE;
                        end
                    end else if (tick && !count_is_zero) begin
                        do_dec = 1'b1;
                    end
                end
                PAUSED: begin
                    if (start) begin
                        next_state = RUN;
                    end
                end
                DONE: begin
                    next_state = IDLE;
                    done_next  = 1'b1;
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_down_counter.sv
// Scoreboard bench for bcd_down_counter: directed vectors queue expectations, a negedge monitor compares.
module tb_bcd_down_counter;

    localparam int DIGITS = 4;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic                load = 1'b0;
    logic [4*DIGITS-1:0] load_value = '0;
    logic                start = 1'b0;
    logic                pause = 1'b0;
    logic                tick = 1'b0;
    logic [4*DIGITS-1:0] count;
    logic                busy;
    logic                done;

    typedef struct {
        logic [15:0] count;
        logic        busy;
        logic        done;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    bcd_down_counter #(.DIGITS(DIGITS)) dut (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .pause      (pause),
        .tick       (tick),
        .count      (count),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    task automatic push_exp(input logic [15:0] ec, input logic eb, input logic ed, input string nm);
        exp_t e;
        e.count = ec;
        e.busy  = eb;
        e.done  = ed;
        e.name  = nm;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic ld, input logic [15:0] lv, input logic st,
                                 input logic ps, input logic tk, input logic [15:0] ec,
                                 input logic eb, input logic ed, input string nm);
        load       = ld;
        load_value = lv;
        start      = st;
        pause      = ps;
        tick       = tk;
        @(posedge clock);
        #1;
        push_exp(ec, eb, ed, nm);
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (count !== e.count || busy !== e.busy || done !== e.done) begin
            errors++;
            $display("[TB] FAIL %s: got count=%h busy=%b done=%b, expected count=%h busy=%b done=%b",
                     e.name, count, busy, done, e.count, e.busy, e.done);
        end
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            checkOutput(exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] down_tbl [12];
        down_tbl = '{16'h0011, 16'h0010, 16'h0009, 16'h0008, 16'h0007, 16'h0006,
                     16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'h0000};

        // Held in reset with tick toggling, then released
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, i[0], 16'h0000, 1'b0, 1'b0, "reset_hold");
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, i[0], 16'h0000, 1'b0, 1'b0, "reset_release");
        end

        // Countdown 0012 -> 0000 with a single done pulse afterwards
        applyStimulus(1'b1, 16'h0012, 1'b0, 1'b0, 1'b0, 16'h0012, 1'b0, 1'b0, "cd_load");
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0012, 1'b1, 1'b0, "cd_start");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, down_tbl[i], (i < 11), 1'b0, "cd_tick");
        end
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, "cd_done_pulse");
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, "cd_done_clear");

        // Borrow chain
        applyStimulus(1'b1, 16'h1000, 1'b0, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, "brw_load1000");
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h1000, 1'b1, 1'b0, "brw_start");
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0999, 1'b1, 1'b0, "brw_0999");
        applyStimulus(1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, "brw_load0100");
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0100, 1'b1, 1'b0, "brw_start2");
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0099, 1'b1, 1'b0, "brw_0099");

        // Pause and resume
        applyStimulus(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, "ps_load");
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0005, 1'b1, 1'b0, "ps_start");
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0004, 1'b1, 1'b0, "ps_tick1");
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b1, 1'b0, "ps_tick2");
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0003, 1'b1, 1'b0, "ps_pause_tick");
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b1, 1'b0, "ps_paused_tick");
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b1, 1'b0, "ps_paused_tick");
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0003, 1'b1, 1'b0, "ps_resume");
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, "ps_tick3");
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, "ps_tick4");
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, "ps_tick5");
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, "ps_done_pulse");
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, "ps_done_clear");

        // Start and pause together while running: pause wins
        applyStimulus(1'b1, 16'h0007, 1'b0, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, "sp_load");
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0007, 1'b1, 1'b0, "sp_start");
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0007, 1'b1, 1'b0, "sp_both");
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0007, 1'b1, 1'b0, "sp_paused_tick");
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0007, 1'b1, 1'b0, "sp_resume");
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0006, 1'b1, 1'b0, "sp_tick");

        // Clamp on load and load priority over tick
        applyStimulus(1'b1, 16'h00FA, 1'b0, 1'b0, 1'b0, 16'h0099, 1'b0, 1'b0, "cl_clamp");
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0099, 1'b1, 1'b0, "cl_start");
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0098, 1'b1, 1'b0, "cl_tick");
        applyStimulus(1'b1, 16'h0042, 1'b0, 1'b0, 1'b1, 16'h0042, 1'b0, 1'b0, "cl_load_vs_tick");
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0042, 1'b0, 1'b0, "cl_idle_tick");

        // Load during DONE suppresses the done pulse
        applyStimulus(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, "ld_load1");
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, "ld_start");
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, "ld_to_done");
        applyStimulus(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, "ld_in_done");
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, "ld_no_done");

        // Start with a zero count is ignored
        applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, "z_load");
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, "z_start");
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, "z_no_done");

        // Asynchronous reset in the middle of a run
        applyStimulus(1'b1, 16'h0050, 1'b0, 1'b0, 1'b0, 16'h0050, 1'b0, 1'b0, "ar_load");
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0050, 1'b1, 1'b0, "ar_start");
        start = 1'b0;
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        push_exp(16'h0000, 1'b0, 1'b0, "ar_async_clear");
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, "ar_hold");
        reset = 1'b1;
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, "ar_no_done");

`ifdef BCD_DOWN_AUTORELOAD_EN
        applyStimulus(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, "rl_load");
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0003, 1'b1, 1'b0, "rl_start");
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, "rl_t1");
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, "rl_t2");
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b1, 1'b1, "rl_reload1");
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, "rl_t4");
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, "rl_t5");
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b1, 1'b1, "rl_reload2");
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b1, 1'b0, "rl_hold");
`endif

        load  = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        tick  = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clock);
            #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
